// File: rtl/cpu_param.sv
// Parametrised accumulator CPU: 8-opcode ISA, PC/AR of ADDR_W bits, and memory
// accessed through a request/ready handshake that tolerates any number of wait states.
module cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ac_out,
  output logic              carry,
  output logic              zero,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  if (DATA_W < ADDR_W + 3) begin : g_width_check
    $error("cpu_param: DATA_W must be at least ADDR_W+3");
  end

  typedef enum logic [2:0] {
    S_F1, S_F2, S_F3, S_RD, S_WR, S_EX, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_JMP = 3'b010,
    OP_INC = 3'b011,
    OP_LDA = 3'b100,
    OP_STA = 3'b101,
    OP_JZ  = 3'b110,
    OP_HLT = 3'b111
  } op_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, ar;
  logic [DATA_W-1:0] dr, ac;
  op_t               ir;
  op_t               dr_op;

  // Carry is the extra top bit of a DATA_W+1-bit sum.
  function automatic logic [DATA_W:0] add_c(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign dr_op = op_t'(dr[DATA_W-1 -: 3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_F1;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_F1: state_nxt = S_F2;
      S_F2: begin
        mem_req = 1'b1;
        if (mem_ready) state_nxt = S_F3;
      end
      S_F3: begin
        case (dr_op)
          OP_ADD, OP_AND, OP_LDA: state_nxt = S_RD;
          OP_STA:                 state_nxt = S_WR;
          OP_HLT:                 state_nxt = S_HALT;
          default:                state_nxt = S_EX;
        endcase
      end
      S_RD: begin
        mem_req = 1'b1;
        if (mem_ready) state_nxt = S_EX;
      end
      S_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) state_nxt = S_F1;
      end
      S_EX:   state_nxt = S_F1;
      S_HALT: halted = 1'b1;
      default: state_nxt = S_F1;
    endcase
  end

  // AR and AC only change outside the request states, so address and write
  // data stay stable for as long as a request is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      ar    <= '0;
      dr    <= '0;
      ac    <= '0;
      ir    <= OP_ADD;
      carry <= 1'b0;
    end else begin
      case (state)
        S_F1: ar <= pc;
        S_F2: begin
          if (mem_ready) begin
            dr <= mem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        S_F3: begin
          ir <= dr_op;
          ar <= dr[ADDR_W-1:0];
        end
        S_RD: begin
          if (mem_ready) dr <= mem_rdata;
        end
        S_EX: begin
          case (ir)
            OP_ADD: {carry, ac} <= add_c(ac, dr);
            OP_AND: ac <= ac & dr;
            OP_JMP: pc <= ar;
            OP_INC: {carry, ac} <= add_c(ac, DATA_W'(1));
            OP_LDA: ac <= dr;
            OP_JZ:  if (ac == '0) pc <= ar;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = ar;
  assign mem_wdata = ac;
  assign ac_out    = ac;
  assign pc_out    = pc;
  assign zero      = (ac == '0);

endmodule

// File: tb/tb_cpu_param.sv
// Bench for cpu_param: a wait-stating memory responder checks every completed
// access against an instruction-level interpreter of the program image.
module tb_cpu_param;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int MW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem_wdata, ac_out;
  logic          mem_req, mem_we, carry, zero, halted;
  logic          mem_ready = 1'b0;

  cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .ac_out    (ac_out),
    .carry     (carry),
    .zero      (zero),
    .halted    (halted),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wd;
    logic          fetch;
  } txn_t;

  txn_t          exp_q[$];
  int            fetch_log[$];
  logic [DW-1:0] mem [MW];
  logic [DW-1:0] mm  [MW];
  int            m_ac, m_cy, m_pc;
  int            n_chk = 0, n_fail = 0, cyc = 0;
  int            wait_lo = 0, wait_hi = 0, wait_left = 0;
  bit            pending = 0, stall_en = 0, pc_track = 0;
  int            stall_addr = 0;
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wd;
  int            n_fetch = 0, we_cyc = 0, req_cyc = 0, t_addr1 = -1;
  int            wrap_seq[8] = '{0, 3, 4, 5, 6, 31, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Instruction-level interpreter: produces the ordered list of memory accesses
  // and the architectural state at HLT.
  task automatic model_run();
    int   pc, ac, cy, op, a, s;
    bit   hlt;
    txn_t t;
    exp_q.delete();
    for (int i = 0; i < MW; i++) mm[i] = mem[i];
    pc = 0; ac = 0; cy = 0; hlt = 0;
    for (int n = 0; n < 1000 && !hlt; n++) begin
      t.addr = AW'(pc); t.we = 1'b0; t.wd = '0; t.fetch = 1'b1;
      exp_q.push_back(t);
      op = int'(mm[pc]) / (1 << (DW - 3));
      a  = int'(mm[pc]) % MW;
      pc = (pc + 1) % MW;
      t.fetch = 1'b0;
      t.addr  = AW'(a);
      case (op)
        0: begin exp_q.push_back(t); s = ac + int'(mm[a]); ac = s % (1 << DW); cy = s / (1 << DW); end
        1: begin exp_q.push_back(t); ac = ac & int'(mm[a]); end
        2: pc = a;
        3: begin s = ac + 1; ac = s % (1 << DW); cy = s / (1 << DW); end
        4: begin exp_q.push_back(t); ac = int'(mm[a]); end
        5: begin t.we = 1'b1; t.wd = DW'(ac); exp_q.push_back(t); mm[a] = DW'(ac); end
        6: if (ac == 0) pc = a;
        default: hlt = 1;
      endcase
    end
    m_ac = ac; m_cy = cy; m_pc = pc;
  endtask

  task automatic complete();
    txn_t e;
    if (exp_q.size() == 0) begin
      chk("txn_extra", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("txn_addr", 32'(mem_addr), 32'(e.addr));
    chk("txn_we", 32'(mem_we), 32'(e.we));
    if (e.we) chk("txn_wdata", 32'(mem_wdata), 32'(e.wd));
    if (mem_we) mem[mem_addr] = mem_wdata;
    if (e.fetch) begin
      n_fetch++;
      fetch_log.push_back(int'(mem_addr));
    end
  endtask

  // Memory side, evaluated on the falling edge: decide mem_ready for the next
  // rising edge and check that stalled requests hold still.
  task automatic respond();
    if (pc_track) chk("pc_track", 32'(pc_out), 32'(n_fetch % MW));
    if (mem_req) begin
      req_cyc++;
      if (mem_we) we_cyc++;
      if (pending) begin
        chk("hold_addr", 32'(mem_addr), 32'(h_addr));
        chk("hold_we", 32'(mem_we), 32'(h_we));
        if (h_we) chk("hold_wdata", 32'(mem_wdata), 32'(h_wd));
      end else begin
        h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
        wait_left = int'($urandom_range(wait_hi, wait_lo));
        if (mem_addr == AW'(1) && t_addr1 < 0) t_addr1 = cyc;
      end
      mem_rdata = mem[mem_addr];
      if ((stall_en && int'(mem_addr) == stall_addr) || wait_left > 0) begin
        mem_ready = 1'b0;
        pending   = 1;
        if (wait_left > 0) wait_left--;
      end else begin
        mem_ready = 1'b1;
        pending   = 0;
        complete();
      end
    end else begin
      if (pending) begin
        chk("req_withdrawn", 32'(mem_req), 32'd1);
        pending = 0;
      end
      mem_ready = 1'($urandom_range(1, 0));
      mem_rdata = DW'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    respond();
  endtask

  task automatic assert_rst();
    @(negedge clk);
    rst = 1'b1; pending = 0; wait_left = 0; mem_ready = 1'b0;
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0; pending = 0; cyc = 0; n_fetch = 0; we_cyc = 0; req_cyc = 0; t_addr1 = -1;
    fetch_log.delete();
    model_run();
    #1;
    respond();
  endtask

  task automatic start_prog();
    assert_rst();
    release_rst();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MW; i++) mem[i] = '0;
  endtask

  task automatic run_to_halt(input int budget);
    while (!halted && cyc < budget) step();
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_final();
    int diffs;
    diffs = 0;
    chk("final_ac", 32'(ac_out), 32'(m_ac));
    chk("final_carry", 32'(carry), 32'(m_cy));
    chk("final_pc", 32'(pc_out), 32'(m_pc));
    chk("final_zero", 32'(zero), (m_ac == 0) ? 32'd1 : 32'd0);
    chk("txn_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < MW; i++) if (mem[i] !== mm[i]) diffs++;
    chk("final_mem", 32'(diffs), 32'd0);
    req_cyc = 0;
    repeat (4) step();
    chk("post_halt_req", 32'(req_cyc), 32'd0);
    chk("post_halt_halted", 32'(halted), 32'd1);
  endtask

  task automatic gen_random_prog();
    int op, a;
    for (int i = 0; i < MW; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 15; i++) begin
      op = int'($urandom_range(7, 0));
      if (op == 0 || op == 1 || op == 4 || op == 5) a = int'($urandom_range(31, 16));
      else if (op == 2 || op == 6)                  a = int'($urandom_range(15, i + 1));
      else                                          a = int'($urandom_range(31, 0));
      mem[i] = DW'(op * 32 + a);
    end
    mem[15] = 8'hE0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_ac", 32'(ac_out), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);

    // Reset while a fetch is stalled in F2.
    clear_mem();
    mem[0] = 8'h8A; mem[1] = 8'hE0; mem[10] = 8'h5A;
    wait_lo = 0; wait_hi = 0; stall_en = 1; stall_addr = 1;
    start_prog();
    while (!(mem_req && mem_addr == AW'(1)) && cyc < 50) step();
    chk("f2_stall_reached", 32'(mem_req && mem_addr == AW'(1)), 32'd1);
    step(); step();
    chk("f2_ac_before", 32'(ac_out), 32'h5A);
    chk("f2_pc_before", 32'(pc_out), 32'd1);
    rst = 1'b1; pending = 0;
    #1;
    chk("f2_rst_req", 32'(mem_req), 32'd0);
    chk("f2_rst_ac", 32'(ac_out), 32'd0);
    chk("f2_rst_pc", 32'(pc_out), 32'd0);
    chk("f2_rst_addr", 32'(mem_addr), 32'd0);
    stall_en = 0;
    release_rst();
    chk("rel_req_c1", 32'(mem_req), 32'd0);
    step();
    chk("rel_req_c2", 32'(mem_req), 32'd1);
    chk("rel_addr_c2", 32'(mem_addr), 32'd0);
    run_to_halt(200);
    check_final();

    // Straight-line program with memory always ready.
    clear_mem();
    mem[0] = 8'h8A; mem[1] = 8'h0B; mem[2] = 8'hAC; mem[3] = 8'hE0;
    mem[10] = 8'hF0; mem[11] = 8'h20;
    pc_track = 1;
    start_prog();
    while (!halted && cyc < 100) step();
    chk("prog_cycles", 32'(cyc), 32'd17);
    chk("prog_we_cycles", 32'(we_cyc), 32'd1);
    chk("prog_m12", 32'(mem[12]), 32'h10);
    chk("prog_carry", 32'(carry), 32'd1);
    chk("prog_pc", 32'(pc_out), 32'd4);
    chk("prog_ac", 32'(ac_out), 32'h10);
    check_final();

    // Three wait states on every access of an ADD.
    clear_mem();
    mem[0] = 8'h0A; mem[1] = 8'hE0; mem[10] = 8'h33;
    wait_lo = 3; wait_hi = 3;
    start_prog();
    run_to_halt(200);
    chk("wait_next_fetch_cycle", 32'(t_addr1), 32'd12);
    chk("wait_ac", 32'(ac_out), 32'h33);
    check_final();
    pc_track = 0;

    // INC then JZ, once from all-ones and once from 0x01.
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0] = 8'h8A; mem[1] = 8'h60; mem[2] = 8'hC7; mem[3] = 8'hE0; mem[7] = 8'hE0;
      mem[10] = (k == 0) ? 8'hFF : 8'h01;
      wait_lo = 0; wait_hi = 1;
      start_prog();
      run_to_halt(300);
      chk("jz_ac", 32'(ac_out), (k == 0) ? 32'h00 : 32'h02);
      chk("jz_carry", 32'(carry), (k == 0) ? 32'd1 : 32'd0);
      chk("jz_zero", 32'(zero), (k == 0) ? 32'd1 : 32'd0);
      chk("jz_next_fetch", (fetch_log.size() > 3) ? 32'(fetch_log[3]) : 32'hFFFF_FFFF,
          (k == 0) ? 32'd7 : 32'd3);
      chk("jz_pc", 32'(pc_out), (k == 0) ? 32'd8 : 32'd4);
      check_final();
    end

    // Jump to the top address, wrap to 0, AND keeps carry.
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'hE0; mem[3] = 8'h94; mem[4] = 8'h60; mem[5] = 8'h96;
    mem[6] = 8'h5F; mem[31] = 8'h35; mem[20] = 8'hFF; mem[21] = 8'h0F; mem[22] = 8'h3C;
    wait_lo = 0; wait_hi = 2;
    start_prog();
    run_to_halt(400);
    chk("wrap_nfetch", 32'(fetch_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("wrap_fetch", (i < fetch_log.size()) ? 32'(fetch_log[i]) : 32'hFFFF_FFFF,
          32'(wrap_seq[i]));
    chk("wrap_ac", 32'(ac_out), 32'h0C);
    chk("wrap_carry", 32'(carry), 32'd1);
    chk("wrap_pc", 32'(pc_out), 32'd2);
    check_final();

    // Reset while a store is stalled.
    clear_mem();
    mem[0] = 8'h8A; mem[1] = 8'hAC; mem[2] = 8'hE0; mem[10] = 8'h5A; mem[12] = 8'h77;
    wait_lo = 0; wait_hi = 0; stall_en = 1; stall_addr = 12;
    start_prog();
    while (!(mem_req && mem_we) && cyc < 60) step();
    chk("wr_reached", 32'(mem_req && mem_we), 32'd1);
    step(); step();
    chk("wr_still_req", 32'(mem_req), 32'd1);
    chk("wr_still_we", 32'(mem_we), 32'd1);
    rst = 1'b1; pending = 0;
    #1;
    chk("wr_rst_req", 32'(mem_req), 32'd0);
    chk("wr_rst_we", 32'(mem_we), 32'd0);
    chk("wr_rst_ac", 32'(ac_out), 32'd0);
    chk("wr_no_write", 32'(mem[12]), 32'h77);
    stall_en = 0;
    release_rst();
    run_to_halt(200);
    check_final();
    chk("wr_after_rerun", 32'(mem[12]), 32'h5A);

    // Random forward-flowing programs with random wait states.
    for (int p = 0; p < 25; p++) begin
      gen_random_prog();
      wait_lo = 0; wait_hi = 3;
      start_prog();
      run_to_halt(3000);
      check_final();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
